// File: rtl/stopwatch_up.sv
// MM:SS up-counting stopwatch with run/pause, lap freeze and saturation at 59:59.
// All outputs are registered from the next-state values, so they track the state register exactly.
module stopwatch_up #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [3:0] bin0,
  output logic [3:0] bin1,
  output logic [3:0] bin2,
  output logic [3:0] bin3,
  output logic       running,
  output logic       lap_active,
  output logic       full
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    LAP   = 3'd3,
    FULL  = 3'd4
  } state_t;

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [15:0] COUNT_MAX = 16'h5959;

  state_t        state_r, state_s;
  logic [15:0]   count_r, count_s;
  logic [15:0]   lap_r, lap_s;
  logic [PW-1:0] presc_r, presc_s;
  logic [15:0]   disp_s;
  logic          counting_s;
  logic          tick_s;

  // Caller guarantees c is below 59:59, so the minutes-tens digit never exceeds 5.
  function automatic logic [15:0] bcd_inc(input logic [15:0] c);
    logic [15:0] r;
    r = c;
    if (c[3:0] != 4'd9) begin
      r[3:0] = c[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (c[7:4] != 4'd5) begin
        r[7:4] = c[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        if (c[11:8] != 4'd9) begin
          r[11:8] = c[11:8] + 4'd1;
        end else begin
          r[11:8]  = 4'd0;
          r[15:12] = c[15:12] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  // Next-state: prescaler, counting, FSM transitions, clear override and display select.
  always_comb begin
    state_s    = state_r;
    count_s    = count_r;
    lap_s      = lap_r;
    presc_s    = presc_r;
    counting_s = (state_r == RUN) || (state_r == LAP);
    tick_s     = counting_s && (presc_r == TICK_LAST);

    if (tick_s) begin
      presc_s = {PW{1'b0}};
    end else if (counting_s) begin
      presc_s = presc_r + PW'(1);
    end else begin
      presc_s = presc_r;
    end

    if (tick_s && (count_r != COUNT_MAX)) begin
      count_s = bcd_inc(count_r);
    end else begin
      count_s = count_r;
    end

    case (state_r)
      IDLE: begin
        if (start_stop) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (start_stop) begin
          state_s = PAUSE;
        end else if (lap) begin
          state_s = LAP;
          lap_s   = count_r;
        end else begin
          state_s = RUN;
        end
      end
      LAP: begin
        if (start_stop) begin
          state_s = PAUSE;
        end else if (lap) begin
          state_s = RUN;
        end else begin
          state_s = LAP;
        end
      end
      PAUSE: begin
        if (start_stop) begin
          state_s = RUN;
        end else begin
          state_s = PAUSE;
        end
      end
      FULL: begin
        state_s = FULL;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Saturation beats any run/pause/lap request arriving on the final tick.
    if (tick_s && (count_r == COUNT_MAX)) begin
      state_s = FULL;
    end else begin
      state_s = state_s;
    end

    if (clear) begin
      state_s = IDLE;
      count_s = 16'h0000;
      lap_s   = 16'h0000;
      presc_s = {PW{1'b0}};
    end else begin
      state_s = state_s;
    end

    if (state_s == LAP) begin
      disp_s = lap_s;
    end else begin
      disp_s = count_s;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      count_r    <= 16'h0000;
      lap_r      <= 16'h0000;
      presc_r    <= {PW{1'b0}};
      bin0       <= 4'd0;
      bin1       <= 4'd0;
      bin2       <= 4'd0;
      bin3       <= 4'd0;
      running    <= 1'b0;
      lap_active <= 1'b0;
      full       <= 1'b0;
    end else begin
      state_r    <= state_s;
      count_r    <= count_s;
      lap_r      <= lap_s;
      presc_r    <= presc_s;
      bin0       <= disp_s[3:0];
      bin1       <= disp_s[7:4];
      bin2       <= disp_s[11:8];
      bin3       <= disp_s[15:12];
      running    <= (state_s == RUN) || (state_s == LAP);
      lap_active <= (state_s == LAP);
      full       <= (state_s == FULL);
    end
  end

endmodule

// File: tb/tb_stopwatch_up.sv
// Scoreboard bench for stopwatch_up: a seconds-based reference model queues expected outputs,
// a monitor compares them one cycle later; directed checks cover the key scenarios.
module tb_stopwatch_up;

  localparam int TD = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3, M_FULL = 4;

  logic clk = 1'b0;
  logic reset = 1'b0, start_stop = 1'b0, lap = 1'b0, clear = 1'b0;
  logic [3:0] bin0, bin1, bin2, bin3;
  logic running, lap_active, full;

  int compared = 0;
  int mismatched = 0;
  logic [18:0] exp_q[$];

  int m_mode = M_IDLE;
  int m_sec = 0;
  int m_lap = 0;
  int m_pre = 0;

  stopwatch_up #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .lap(lap), .clear(clear),
    .bin0(bin0), .bin1(bin1), .bin2(bin2), .bin3(bin3),
    .running(running), .lap_active(lap_active), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [18:0] model_out();
    int d, mm, ss;
    d  = (m_mode == M_LAP) ? m_lap : m_sec;
    mm = d / 60;
    ss = d % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
            1'((m_mode == M_RUN) || (m_mode == M_LAP)), 1'(m_mode == M_LAP), 1'(m_mode == M_FULL)};
  endfunction

  // Reference model: one clock edge of the stopwatch rules, time kept as plain seconds.
  task automatic model_step(input logic r, input logic ss, input logic lp, input logic cl);
    bit counting, tick, sat;
    if (r || cl) begin
      m_mode = M_IDLE; m_sec = 0; m_lap = 0; m_pre = 0;
    end else begin
      counting = (m_mode == M_RUN) || (m_mode == M_LAP);
      tick = counting && (m_pre == TD - 1);
      sat = tick && (m_sec == 3599);
      if (counting) m_pre = (m_pre + 1) % TD;
      case (m_mode)
        M_IDLE:  if (ss) m_mode = M_RUN;
        M_RUN:   if (ss) m_mode = M_PAUSE;
                 else if (lp) begin m_mode = M_LAP; m_lap = m_sec; end
        M_LAP:   if (ss) m_mode = M_PAUSE; else if (lp) m_mode = M_RUN;
        M_PAUSE: if (ss) m_mode = M_RUN;
        default: ;
      endcase
      if (sat) m_mode = M_FULL;
      else if (tick) m_sec = m_sec + 1;
    end
  endtask

  // Called at a negedge; drives one cycle of inputs, queues the expectation, returns at the next negedge.
  task automatic step(input logic r, input logic ss, input logic lp, input logic cl);
    reset = r; start_stop = ss; lap = lp; clear = cl;
    model_step(r, ss, lp, cl);
    exp_q.push_back(model_out());
    @(negedge clk);
    reset = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_disp(input string name, input logic [15:0] d, input logic [2:0] flags);
    chk(name, {bin3, bin2, bin1, bin0, running, lap_active, full}, {d, flags});
  endtask

  // Monitor: after every active edge the DUT presents a fresh output word; compare with the queue head.
  initial begin
    logic [18:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("scoreboard", {bin3, bin2, bin1, bin0, running, lap_active, full}, e);
      end
    end
  end

  initial begin
    int r;
    @(negedge clk);
    reset = 1'b1; start_stop = 1'b1; lap = 1'b1;
    @(negedge clk);
    chk_disp("reset_outputs", 16'h0000, 3'b000);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk_disp("reset_idle", 16'h0000, 3'b000);

    // Count-up and minute carry
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(40);
    chk_disp("count_up_0010", 16'h0010, 3'b100);
    idle(49 * TD);
    chk_disp("at_0059", 16'h0059, 3'b100);
    idle(TD);
    chk_disp("minute_carry", 16'h0100, 3'b100);

    // Lap hold
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(20);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(12);
    chk_disp("lap_hold", 16'h0005, 3'b110);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk_disp("lap_release", 16'h0008, 3'b100);

    // Pause holds count and prescaler
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3 * TD + 2);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(100);
    chk_disp("pause_hold", 16'h0003, 3'b000);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk_disp("pause_resume", 16'h0004, 3'b100);

    // Clear beats start_stop in RUN
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk_disp("clear_priority", 16'h0000, 3'b000);

    // Randomized phase
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 999));
      step(r < 2, ($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 4), (r >= 2 && r < 6));
    end

    // Saturation
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3599 * TD);
    chk_disp("at_5959", 16'h5959, 3'b100);
    idle(TD);
    chk_disp("saturate_full", 16'h5959, 3'b001);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(2 * TD);
    chk_disp("full_ignores", 16'h5959, 3'b001);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk_disp("full_clear", 16'h0000, 3'b000);

    // Reset mid-run in LAP at 12:34
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(754 * TD);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(TD);
    chk_disp("lap_1234", 16'h1234, 3'b110);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk_disp("reset_in_lap", 16'h0000, 3'b000);

    idle(2);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/stopwatch_up.md
STOPWATCH_UP -- requirements
Module: stopwatch_up

Interface
REQ-001 Parameter: TICK_DIV, default 50000000, clk cycles per counted second (legal range 2 and up).
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  reset, synchronous, active-high.
REQ-004 Port: start_stop  input  1  single-cycle pulse, already debounced; toggles run/pause.
REQ-005 Port: lap  input  1  single-cycle pulse, already debounced; freezes/unfreezes the displayed value.
REQ-006 Port: clear  input  1  single-cycle pulse; returns the block to 00:00 idle.
REQ-007 Port: bin0  output  4  displayed seconds-ones digit, BCD 0-9.
REQ-008 Port: bin1  output  4  displayed seconds-tens digit, BCD 0-5.
REQ-009 Port: bin2  output  4  displayed minutes-ones digit, BCD 0-9.
REQ-010 Port: bin3  output  4  displayed minutes-tens digit, BCD 0-5.
REQ-011 Port: running  output  1  high in RUN or LAP.
REQ-012 Port: lap_active  output  1  high in LAP only.
REQ-013 Port: full  output  1  high in FULL only.

Function
REQ-014 Block SHALL hold a live BCD count c3:c2:c1:c0 (MM:SS), a lap-hold register, a prescaler, and a 5-state FSM: IDLE, RUN, PAUSE, LAP, FULL.
REQ-015 Prescaler SHALL advance by one only in RUN or LAP, wrapping TICK_DIV-1 -> 0; the wrap cycle is the "tick".
REQ-016 Prescaler SHALL hold its value in PAUSE, IDLE and FULL, and SHALL clear to 0 on reset or clear.
REQ-017 On tick, the live count SHALL increment, registered, visible on the cycle after the wrap edge.
REQ-018 Increment carries SHALL be: c0 9->0 carry; c1 5->0 carry; c2 9->0 carry; c3 increments up to 5.
REQ-019 A tick at 59:59 SHALL leave the count at 59:59 and enter FULL; the count never wraps to 00:00.
REQ-020 IDLE transition: start_stop -> RUN; lap ignored.
REQ-021 RUN transitions: start_stop -> PAUSE; lap -> LAP with the live count copied into the lap-hold register.
REQ-022 LAP: counting SHALL continue. lap -> RUN; start_stop -> PAUSE.
REQ-023 PAUSE transitions: start_stop -> RUN, resuming with the held prescaler value; lap ignored.
REQ-024 FULL: start_stop and lap SHALL be ignored.
REQ-025 clear in any state SHALL: enter IDLE; zero count, lap-hold and prescaler.
REQ-026 Event priority SHALL be reset > clear > start_stop > lap; lower-priority pulses in the same cycle are discarded.
REQ-027 A tick coinciding with start_stop or lap (in RUN/LAP) SHALL still increment the count.
REQ-028 A lap capture coinciding with a tick SHALL store the pre-increment count.
REQ-029 bin0-bin3 SHALL show the lap-hold register in LAP and the live count in all other states.
REQ-030 All outputs SHALL be registered; running, lap_active and full SHALL decode the state register with no combinational path from inputs.

Reset
REQ-031 reset high at a clk edge SHALL force IDLE, count 00:00, lap-hold 00:00, prescaler 0.
REQ-032 While reset is high, bin0-bin3, running, lap_active and full SHALL all be 0.
REQ-033 reset SHALL override all other inputs in the same cycle; there is no asynchronous path.

Verification (TICK_DIV=4)
REQ-034 Count-up: reset, start_stop, 40 clk -> 00:10 (bin1=1, others 0), running=1.
REQ-035 Minute carry: run from 00:59 for one tick -> 01:00 (bin2=1, bin1=0, bin0=0).
REQ-036 Lap hold: lap at 00:05, 12 clk later -> display 00:05, lap_active=1; second lap -> display 00:08, lap_active=0.
REQ-037 Pause: start_stop at 00:03 plus 2 prescaler counts, wait 100 clk -> 00:03, running=0; start_stop -> 00:04 after 2 clk.
REQ-038 Saturation: preload to 59:59 via 3599 ticks, one more tick -> 59:59, full=1; start_stop ignored; clear -> 00:00, IDLE.
REQ-039 Simultaneous events: clear and start_stop in the same cycle during RUN -> IDLE, 00:00, running=0.
REQ-040 Reset mid-run: reset at 12:34 in LAP -> next cycle all outputs 0, state IDLE.
